// File: rtl/seq_core_pkg.sv
// Shared definitions for the sequencer-core fetch path: default widths,
// the NOP encoding loaded into ir on bubbles/flushes, and the per-cycle
// action decode used by the fetch buffer.
package seq_core_pkg;

   localparam int A_SIZE_DEF = 10;
   localparam int I_SIZE_DEF = 16;
   localparam int NOP_ENC    = 0;

   // What the fetch buffer does this cycle, highest priority first.
   typedef enum logic [2:0] {
      ACT_HALT   = 3'd0,
      ACT_REDIR  = 3'd1,
      ACT_FLUSH  = 3'd2,
      ACT_BUBBLE = 3'd3,
      ACT_RUN    = 3'd4
   } fetch_act_e;

   function automatic fetch_act_e decode_act(input logic halt,
                                             input logic redir,
                                             input logic flush,
                                             input logic bubble);
      if (halt)   return ACT_HALT;
      if (redir)  return ACT_REDIR;
      if (flush)  return ACT_FLUSH;
      if (bubble) return ACT_BUBBLE;
      return ACT_RUN;
   endfunction

endpackage

// File: rtl/seq_core_fetch_fifo.sv
// Prefetch queue for the fetch buffer. DEPTH must be a power of two so the
// read/write pointers wrap naturally. A clear wins over push/pop in the same
// cycle; push and pop together keep the level unchanged (legal when full).
module seq_core_fetch_fifo #(
   parameter int W     = 26,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [W-1:0]                 wdata_i,
   output logic [W-1:0]                 rdata_o,
   output logic [$clog2(DEPTH+1)-1:0]   level_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int LW = $clog2(DEPTH+1);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push_i && !clr_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

endmodule

// File: rtl/seq_core_fetch_buf.sv
// Fetch buffer for the sequencer core: drives the program-memory address,
// prefetches into a small queue and feeds the decode-stage IR.
// Optional feature: define SEQ_CORE_FETCH_BYPASS_EN to let a fetch go
// straight into ir when the queue is empty and decode is ready for it,
// cutting fetch-to-ir latency from two cycles to one.
module seq_core_fetch_buf
   import seq_core_pkg::*;
#(
   parameter int A_SIZE  = A_SIZE_DEF,
   parameter int I_SIZE  = I_SIZE_DEF,
   parameter int Q_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   output logic [A_SIZE-1:0]             pc,
   input  logic [I_SIZE-1:0]             instruction,
   input  logic                          imem_valid,
   input  logic                          r2_pc_halt,
   input  logic                          r2_pc_load,
   input  logic                          r2_pc_loadr,
   input  logic                          r2_pc_flush,
   input  logic [A_SIZE-1:0]             r2_pc_target,
   input  logic                          bubble,
   output logic [I_SIZE-1:0]             ir,
   output logic                          ir_valid,
   output logic [A_SIZE-1:0]             ir_pc,
   output logic [$clog2(Q_DEPTH+1)-1:0]  q_level
);

   localparam int LW = $clog2(Q_DEPTH+1);
   localparam int EW = A_SIZE + I_SIZE;

   fetch_act_e        act;
   logic              pop_slot;
   logic              fifo_pop;
   logic              fifo_push;
   logic              fifo_clr;
   logic              push_ok;
   logic              bypass;
   logic [EW-1:0]     head;
   logic [LW-1:0]     level;

   logic [A_SIZE-1:0] pc_q, pc_d;
   logic [A_SIZE-1:0] ir_pc_q, ir_pc_d;
   logic [I_SIZE-1:0] ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;

   assign act = decode_act(r2_pc_halt, r2_pc_load | r2_pc_loadr, r2_pc_flush, bubble);

   // Decode takes something this cycle: a queued entry, a bypassed fetch or a NOP.
   assign pop_slot = (act == ACT_RUN);
   assign fifo_pop = pop_slot && (level != '0);
   assign push_ok  = (act != ACT_HALT) && (act != ACT_REDIR) && imem_valid &&
                     ((level < LW'(Q_DEPTH)) || fifo_pop);
`ifdef SEQ_CORE_FETCH_BYPASS_EN
   assign bypass   = pop_slot && (level == '0) && push_ok;
`else
   assign bypass   = 1'b0;
`endif
   assign fifo_push = push_ok && !bypass;
   assign fifo_clr  = (act == ACT_REDIR);

   seq_core_fetch_fifo #(
      .W     (EW),
      .DEPTH (Q_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr_i   (fifo_clr),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i ({pc_q, instruction}),
      .rdata_o (head),
      .level_o (level)
   );

   // Next pc and IR contents from the winning action of this cycle.
   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      ir_pc_d    = ir_pc_q;
      unique case (act)
         ACT_REDIR: begin
            pc_d = r2_pc_load ? r2_pc_target : (ir_pc_q + r2_pc_target);
            if (r2_pc_flush) begin
               ir_d       = I_SIZE'(NOP_ENC);
               ir_valid_d = 1'b0;
            end
         end
         ACT_FLUSH: begin
            ir_d       = I_SIZE'(NOP_ENC);
            ir_valid_d = 1'b0;
         end
         ACT_RUN: begin
            if (fifo_pop) begin
               ir_d       = head[I_SIZE-1:0];
               ir_pc_d    = head[EW-1:I_SIZE];
               ir_valid_d = 1'b1;
            end else if (bypass) begin
               ir_d       = instruction;
               ir_pc_d    = pc_q;
               ir_valid_d = 1'b1;
            end else begin
               ir_d       = I_SIZE'(NOP_ENC);
               ir_valid_d = 1'b0;
            end
         end
         default: begin
         end
      endcase
      if (push_ok) begin
         pc_d = pc_q + 1'b1;
      end
   end

   // Fetch address and decode-stage IR registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         ir_pc_q    <= '0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         ir_pc_q    <= ir_pc_d;
      end
   end

   assign pc       = pc_q;
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign ir_pc    = ir_pc_q;
   assign q_level  = level;

endmodule
